// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: dispatch allocation, LSU fill and forwarding search,
// ROB commit/flush and the L1d write handshake.
interface store_buffer_if #(
  parameter int IW = 5
);
  // Dispatch allocation
  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;

  // LSU store fill
  logic          SB_W;
  logic [IW-1:0] SB_index_in;
  logic [15:0]   SB_addr_in;
  logic [15:0]   SB_data_in;

  // Store-to-load forwarding
  logic [15:0]   SB_search_addr;
  logic          SB_match;
  logic [15:0]   SB_data;

  // ROB interaction
  logic          commit_valid;
  logic          flush;

  // L1d write port
  logic          L1d_W;
  logic [15:0]   L1d_W_addr;
  logic [15:0]   L1d_W_data;
  logic          L1d_W_ack;

  // Occupancy status
  logic          sb_full;
  logic          sb_empty;

  // Store buffer side
  modport slave (
    input  alloc_valid, SB_W, SB_index_in, SB_addr_in, SB_data_in,
    input  SB_search_addr, commit_valid, flush, L1d_W_ack,
    output alloc_ready, alloc_index, SB_match, SB_data,
    output L1d_W, L1d_W_addr, L1d_W_data, sb_full, sb_empty
  );

  // Pipeline / memory side
  modport master (
    output alloc_valid, SB_W, SB_index_in, SB_addr_in, SB_data_in,
    output SB_search_addr, commit_valid, flush, L1d_W_ack,
    input  alloc_ready, alloc_index, SB_match, SB_data,
    input  L1d_W, L1d_W_addr, L1d_W_data, sb_full, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer. Entries are allocated in program order, filled by the
// LSU, committed in order by the ROB and drained in order to L1d. Loads search
// all filled entries combinationally; the youngest matching store wins.
module store_buffer #(
  parameter int DEPTH = 32,
  parameter int IW    = 5
) (
  input  logic         clk,
  input  logic         rst,
  store_buffer_if.slave sb
);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } drain_state_t;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IW:0]   r_head;
  logic [IW:0]   r_cmt;
  logic [IW:0]   r_tail;

  // Per-entry state
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_filled;
  logic [DEPTH-1:0] r_committed;
  logic [15:0]      r_addr [DEPTH];
  logic [15:0]      r_data [DEPTH];

  // Drain engine
  drain_state_t  r_state;
  logic          r_l1d_w;
  logic [15:0]   r_l1d_addr;
  logic [15:0]   r_l1d_data;

  // Control decodes
  logic          w_full;
  logic          w_empty;
  logic          w_alloc_fire;
  logic          w_fill_ok;
  logic          w_commit_fire;
  logic          w_drain_done;
  logic [IW:0]   w_cmt_next;
  logic [IW:0]   w_uncmt_cnt;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_tail_idx;
  logic [IW-1:0] w_cmt_idx;

  // Per-entry strobes
  logic [DEPTH-1:0] w_alloc_here;
  logic [DEPTH-1:0] w_fill_here;
  logic [DEPTH-1:0] w_commit_here;
  logic [DEPTH-1:0] w_drain_here;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_hit;

  // Forwarding result
  logic          w_match;
  logic [15:0]   w_fwd_data;

  assign w_head_idx = r_head[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];
  assign w_cmt_idx  = r_cmt[IW-1:0];

  // Full/empty come from registered pointers only, so a drain in the same
  // cycle never creates room for an allocation in that cycle.
  assign w_full  = (r_tail[IW] != r_head[IW]) && (w_tail_idx == w_head_idx);
  assign w_empty = (r_tail == r_head);

  // Allocation and fill are both suppressed during a flush.
  assign w_alloc_fire = sb.alloc_valid && !w_full && !sb.flush;
  assign w_fill_ok    = sb.SB_W && !sb.flush &&
                        r_valid[sb.SB_index_in] && !r_committed[sb.SB_index_in];

  // The ROB retires in order; a commit is only honoured when the next
  // uncommitted entry exists and already holds its address/data.
  assign w_commit_fire = sb.commit_valid && (r_cmt != r_tail) && r_filled[w_cmt_idx];
  assign w_cmt_next    = r_cmt + {{IW{1'b0}}, w_commit_fire};

  // Number of uncommitted entries after this cycle's commit; these are the
  // ones a flush discards.
  assign w_uncmt_cnt = r_tail - w_cmt_next;

  assign w_drain_done = (r_state == ST_WRITE) && sb.L1d_W_ack;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [IW-1:0] IDX = IW'(gi);
      logic [IW-1:0] w_rel;

      // Distance of this slot from the first entry a flush would discard.
      assign w_rel = IDX - w_cmt_next[IW-1:0];

      assign w_kill[gi]        = sb.flush && ({1'b0, w_rel} < w_uncmt_cnt);
      assign w_alloc_here[gi]  = w_alloc_fire  && (w_tail_idx == IDX);
      assign w_fill_here[gi]   = w_fill_ok     && (sb.SB_index_in == IDX);
      assign w_commit_here[gi] = w_commit_fire && (w_cmt_idx == IDX);
      assign w_drain_here[gi]  = w_drain_done  && (w_head_idx == IDX);
      assign w_hit[gi]         = r_valid[gi] && r_filled[gi] &&
                                 (r_addr[gi] == sb.SB_search_addr);
    end
  endgenerate

  // Commit and allocation pointers; a flush rewinds the tail to the commit
  // point after this cycle's commit has been applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      r_cmt <= w_cmt_next;
      if (sb.flush) begin
        r_tail <= w_cmt_next;
      end else if (w_alloc_fire) begin
        r_tail <= r_tail + 1'b1;
      end
    end
  end

  // Per-entry flags and payload: drain retires, flush discards, otherwise
  // alloc/fill/commit update the addressed slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_filled    <= '0;
      r_committed <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_drain_here[i]) begin
          r_valid[i]     <= 1'b0;
          r_filled[i]    <= 1'b0;
          r_committed[i] <= 1'b0;
        end else if (w_kill[i]) begin
          r_valid[i]     <= 1'b0;
          r_filled[i]    <= 1'b0;
          r_committed[i] <= 1'b0;
        end else begin
          if (w_alloc_here[i]) begin
            r_valid[i]     <= 1'b1;
            r_filled[i]    <= 1'b0;
            r_committed[i] <= 1'b0;
          end
          if (w_fill_here[i]) begin
            r_filled[i] <= 1'b1;
            r_addr[i]   <= sb.SB_addr_in;
            r_data[i]   <= sb.SB_data_in;
          end
          if (w_commit_here[i]) begin
            r_committed[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Drain FSM: launch the oldest committed store, hold the request stable
  // until L1d acknowledges, then retire the entry and advance head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_l1d_w    <= 1'b0;
      r_l1d_addr <= '0;
      r_l1d_data <= '0;
      r_head     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_valid[w_head_idx] && r_committed[w_head_idx]) begin
            r_l1d_addr <= r_addr[w_head_idx];
            r_l1d_data <= r_data[w_head_idx];
            r_l1d_w    <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (sb.L1d_W_ack) begin
            r_l1d_w <= 1'b0;
            r_head  <= r_head + 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_l1d_w <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Forwarding search: walk from oldest (head) to youngest so that the last
  // hit seen is the youngest matching store. Slots outside [head, tail) are
  // never valid, so walking the whole ring is safe.
  always_comb begin
    logic [IW-1:0] v_idx;
    w_match    = 1'b0;
    w_fwd_data = '0;
    v_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = w_head_idx + IW'(k);
      if (w_hit[v_idx]) begin
        w_match    = 1'b1;
        w_fwd_data = r_data[v_idx];
      end
    end
  end

  assign sb.alloc_ready = !w_full;
  assign sb.alloc_index = w_tail_idx;
  assign sb.sb_full     = w_full;
  assign sb.sb_empty    = w_empty;
  assign sb.SB_match    = w_match;
  assign sb.SB_data     = w_fwd_data;
  assign sb.L1d_W       = r_l1d_w;
  assign sb.L1d_W_addr  = r_l1d_addr;
  assign sb.L1d_W_data  = r_l1d_data;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios, a queue-based reference model
// of the buffer contents and drain, and a per-cycle compare process.
module tb_store_buffer;
  localparam int DEPTH = 32;
  localparam int IW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.IW(IW)) sbif ();

  store_buffer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The buffer is a program-ordered queue of live stores; committed stores
  // form a prefix. The drain is "idle" or "writing one record".
  typedef struct {
    int         idx;
    bit         filled;
    bit         committed;
    logic [15:0] addr;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_head;
  bit          m_wr;
  logic [15:0] m_wa, m_wd;
  int          m_size, m_nc, m_tidx;
  bit          m_do_commit, m_done, m_start;
  ent_t        m_new;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_head = 0;
      m_wr   = 0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      m_size = mq.size();
      m_nc   = 0;
      while (m_nc < m_size && mq[m_nc].committed) m_nc++;
      m_tidx = (m_head + m_size) % DEPTH;
      m_do_commit = 0;
      if (sbif.commit_valid && m_nc < m_size) begin
        if (mq[m_nc].filled) m_do_commit = 1;
      end
      m_done  = m_wr && sbif.L1d_W_ack;
      m_start = 0;
      if (!m_wr && m_size > 0) begin
        if (mq[0].committed) m_start = 1;
      end
      // fill
      if (sbif.SB_W && !sbif.flush) begin
        for (int k = 0; k < m_size; k++) begin
          if (mq[k].idx == int'(sbif.SB_index_in) && !mq[k].committed) begin
            mq[k].filled = 1;
            mq[k].addr   = sbif.SB_addr_in;
            mq[k].data   = sbif.SB_data_in;
          end
        end
      end
      // commit
      if (m_do_commit) begin
        mq[m_nc].committed = 1;
        m_nc++;
      end
      // flush or alloc
      if (sbif.flush) begin
        while (mq.size() > m_nc) void'(mq.pop_back());
      end else if (sbif.alloc_valid && m_size < DEPTH) begin
        m_new.idx = m_tidx; m_new.filled = 0; m_new.committed = 0;
        m_new.addr = '0; m_new.data = '0;
        mq.push_back(m_new);
      end
      // drain
      if (m_done) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % DEPTH;
        m_wr   = 0;
      end else if (m_start) begin
        m_wr = 1;
        m_wa = mq[0].addr;
        m_wd = mq[0].data;
      end
    end
  end

  // Per-cycle comparison against the model.
  bit          e_match;
  logic [15:0] e_data;
  always @(negedge clk) begin
    if (!rst) begin
      e_match = 0;
      e_data  = '0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (!e_match && mq[k].filled && mq[k].addr == sbif.SB_search_addr) begin
          e_match = 1;
          e_data  = mq[k].data;
        end
      end
      chk("sb_empty",    32'(sbif.sb_empty),    32'(mq.size() == 0));
      chk("sb_full",     32'(sbif.sb_full),     32'(mq.size() == DEPTH));
      chk("alloc_ready", 32'(sbif.alloc_ready), 32'(mq.size() != DEPTH));
      chk("alloc_index", 32'(sbif.alloc_index), 32'((m_head + mq.size()) % DEPTH));
      chk("SB_match",    32'(sbif.SB_match),    32'(e_match));
      chk("SB_data",     32'(sbif.SB_data),     32'(e_data));
      chk("L1d_W",       32'(sbif.L1d_W),       32'(m_wr));
      if (m_wr) begin
        chk("L1d_W_addr", 32'(sbif.L1d_W_addr), 32'(m_wa));
        chk("L1d_W_data", 32'(sbif.L1d_W_data), 32'(m_wd));
      end
    end
  end

  // Log of completed L1d writes, one line per transaction.
  logic [15:0] log_a[$];
  logic [15:0] log_d[$];
  always @(negedge clk) begin
    if (!rst && sbif.L1d_W && sbif.L1d_W_ack) begin
      log_a.push_back(sbif.L1d_W_addr);
      log_d.push_back(sbif.L1d_W_data);
      $display("L1d write addr=0x%04h data=0x%04h at %0t", sbif.L1d_W_addr, sbif.L1d_W_data, $time);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sbif.alloc_valid    = 0;
    sbif.SB_W           = 0;
    sbif.SB_index_in    = '0;
    sbif.SB_addr_in     = '0;
    sbif.SB_data_in     = '0;
    sbif.commit_valid   = 0;
    sbif.flush          = 0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    sbif.L1d_W_ack = 0;
    rst = 1;
    step();
    rst = 0;
    log_a.delete();
    log_d.delete();
  endtask

  task automatic do_alloc(int n);
    sbif.alloc_valid = 1;
    repeat (n) step();
    sbif.alloc_valid = 0;
  endtask

  task automatic do_fill(int idx, logic [15:0] a, logic [15:0] d);
    sbif.SB_W        = 1;
    sbif.SB_index_in = IW'(idx);
    sbif.SB_addr_in  = a;
    sbif.SB_data_in  = d;
    step();
    sbif.SB_W = 0;
  endtask

  task automatic do_commit(int n);
    sbif.commit_valid = 1;
    repeat (n) step();
    sbif.commit_valid = 0;
  endtask

  task automatic wait_l1d(string name);
    int c = 0;
    while (sbif.L1d_W !== 1'b1 && c < 50) begin step(); c++; end
    if (sbif.L1d_W !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: L1d_W never rose, got %b, expected 1", name, sbif.L1d_W);
    end
  endtask

  task automatic wait_empty(string name);
    int c = 0;
    while (sbif.sb_empty !== 1'b1 && c < 200) begin step(); c++; end
    if (sbif.sb_empty !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: buffer never emptied, got %b, expected 1", name, sbif.sb_empty);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    clear_inputs();
    sbif.SB_search_addr = '0;
    sbif.L1d_W_ack      = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_empty",       32'(sbif.sb_empty),    32'd1);
    chk("rst_full",        32'(sbif.sb_full),     32'd0);
    chk("rst_alloc_ready", 32'(sbif.alloc_ready), 32'd1);
    chk("rst_alloc_index", 32'(sbif.alloc_index), 32'd0);
    chk("rst_l1d_w",       32'(sbif.L1d_W),       32'd0);
    chk("rst_l1d_addr",    32'(sbif.L1d_W_addr),  32'd0);
    chk("rst_match",       32'(sbif.SB_match),    32'd0);

    // Forwarding: youngest match wins, unfilled/same-cycle fill not visible
    do_alloc(3);
    do_fill(0, 16'h0010, 16'h1111);
    do_fill(2, 16'h0010, 16'h2222);
    sbif.SB_search_addr = 16'h0010;
    @(negedge clk);
    chk("fwd_match_10", 32'(sbif.SB_match), 32'd1);
    chk("fwd_data_10",  32'(sbif.SB_data),  32'h2222);
    sbif.SB_search_addr = 16'h0020;
    @(negedge clk);
    chk("fwd_match_20", 32'(sbif.SB_match), 32'd0);
    chk("fwd_data_20",  32'(sbif.SB_data),  32'h0000);
    step();
    sbif.SB_search_addr = 16'h0030;
    sbif.SB_W = 1; sbif.SB_index_in = 5'd1; sbif.SB_addr_in = 16'h0030; sbif.SB_data_in = 16'h3333;
    @(negedge clk);
    chk("fwd_same_cycle_hidden", 32'(sbif.SB_match), 32'd0);
    step();
    sbif.SB_W = 0;
    @(negedge clk);
    chk("fwd_next_cycle_visible", 32'(sbif.SB_data), 32'h3333);

    // Fill to full, refuse extra alloc, drain one, wrap index
    pulse_reset();
    do_alloc(33);
    @(negedge clk);
    chk("full_flag",        32'(sbif.sb_full),     32'd1);
    chk("full_alloc_ready", 32'(sbif.alloc_ready), 32'd0);
    do_fill(0, 16'h0050, 16'h5555);
    do_commit(1);
    sbif.L1d_W_ack = 1;
    begin
      int c = 0;
      while (sbif.sb_full === 1'b1 && c < 20) begin step(); c++; end
    end
    sbif.L1d_W_ack = 0;
    @(negedge clk);
    chk("wrap_full_cleared", 32'(sbif.sb_full),     32'd0);
    chk("wrap_alloc_index",  32'(sbif.alloc_index), 32'd0);
    do_alloc(1);
    @(negedge clk);
    chk("wrap_refull", 32'(sbif.sb_full), 32'd1);

    // Alloc 4, fill all, commit 2, flush: two in-order writes only
    pulse_reset();
    sbif.SB_search_addr = 16'h0000;
    do_alloc(4);
    for (int i = 0; i < 4; i++) do_fill(i, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    sbif.L1d_W_ack = 1;
    do_commit(2);
    sbif.flush = 1;
    step();
    sbif.flush = 0;
    wait_empty("flush_drain");
    @(negedge clk);
    chk("flush_writes",      32'(log_a.size()),     32'd2);
    chk("flush_alloc_index", 32'(sbif.alloc_index), 32'd2);
    if (log_a.size() == 2) begin
      chk("flush_w0_addr", 32'(log_a[0]), 32'h0100);
      chk("flush_w0_data", 32'(log_d[0]), 32'hA000);
      chk("flush_w1_addr", 32'(log_a[1]), 32'h0101);
      chk("flush_w1_data", 32'(log_d[1]), 32'hA001);
    end

    // Ack withheld for 5 cycles, then acked
    pulse_reset();
    do_alloc(1);
    do_fill(0, 16'h0200, 16'hBEEF);
    do_commit(1);
    wait_l1d("hold_start");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_l1d_w",    32'(sbif.L1d_W),      32'd1);
      chk("hold_l1d_addr", 32'(sbif.L1d_W_addr), 32'h0200);
      chk("hold_l1d_data", 32'(sbif.L1d_W_data), 32'hBEEF);
      step();
    end
    sbif.L1d_W_ack = 1;
    step();
    sbif.L1d_W_ack = 0;
    @(negedge clk);
    chk("hold_l1d_dropped", 32'(sbif.L1d_W),    32'd0);
    chk("hold_empty",       32'(sbif.sb_empty), 32'd1);

    // Reset while a write is outstanding
    pulse_reset();
    do_alloc(2);
    do_fill(0, 16'h0040, 16'h4444);
    do_commit(1);
    wait_l1d("midrst_start");
    pulse_reset();
    @(negedge clk);
    chk("midrst_l1d_w",       32'(sbif.L1d_W),       32'd0);
    chk("midrst_empty",       32'(sbif.sb_empty),    32'd1);
    chk("midrst_alloc_index", 32'(sbif.alloc_index), 32'd0);

    // Commit and flush in the same cycle
    pulse_reset();
    do_alloc(3);
    for (int i = 0; i < 3; i++) do_fill(i, 16'h0300 + 16'(i), 16'hC000 + 16'(i));
    sbif.L1d_W_ack    = 1;
    sbif.commit_valid = 1;
    sbif.flush        = 1;
    step();
    sbif.commit_valid = 0;
    sbif.flush        = 0;
    wait_empty("cf_drain");
    @(negedge clk);
    chk("cf_writes",      32'(log_a.size()),     32'd1);
    chk("cf_alloc_index", 32'(sbif.alloc_index), 32'd1);
    if (log_a.size() == 1) begin
      chk("cf_w0_addr", 32'(log_a[0]), 32'h0300);
      chk("cf_w0_data", 32'(log_d[0]), 32'hC000);
    end
    sbif.L1d_W_ack = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
